wb_spi_flash_rd: RTL and testbench
==================================

Name: wb_spi_flash_rd

Overview:
Wishbone classic responder that fills the SoC's SPI-flash slave slot on the interconnect. It answers the bus master's read cycles by performing a serial flash READ (0x03) transaction and returning one 32-bit word. The block is read-only; Wishbone writes terminate with an error. SPI side is mode 0, MSB first, single chip select.

Parameters:
CLK_DIV, 2, SCK half-period in wb_clk_i cycles (>=1)
ADDR_W, 24, flash address width sent on SPI (fixed command format uses 24)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous, active-high reset
wb_adr_i  in  32  byte address; [23:2] used, [1:0] and [31:24] ignored
wb_dat_i  in  32  write data (unused, writes rejected)
wb_sel_i  in  4  byte selects (ignored; full word always returned)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination, one-cycle pulse
wb_err_o  out  1  error termination, one-cycle pulse
spi_sck_o  out  1  serial clock, idle low
spi_cs_n_o  out  1  flash chip select, active low
spi_mosi_o  out  1  serial data to flash
spi_miso_i  in  1  serial data from flash

Behaviour:
- Clock wb_clk_i; wb_rst_i is synchronous and active-high. Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, spi_sck_o=0, spi_cs_n_o=1, spi_mosi_o=0, FSM=IDLE, bit counter=0.
- FSM states: IDLE, ERR, CS_SETUP, SHIFT, CS_HOLD, ACK.
- IDLE: if cyc&stb&we, go to ERR. If cyc&stb&!we, latch {adr[23:2],2'b00} and go to CS_SETUP. Otherwise stay in IDLE.
- ERR: wb_err_o=1 for exactly this cycle. No SPI activity. Next state is IDLE.
- CS_SETUP (1 cycle): spi_cs_n_o=0, spi_mosi_o = bit 63 of the frame. Next state is SHIFT.
- SHIFT: 64-bit frame = 0x03, then address[23:0], then 32 data bits.
  - Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - spi_miso_i is sampled on the clk edge that raises SCK.
  - MOSI updates when SCK falls. During the data phase (bits 31..0) MOSI is driven 0.
  - After the last high phase, SCK returns low and the FSM goes to CS_HOLD.
- Received byte k (k=0 first) lands in wb_dat_o[8k+7:8k], i.e. little-endian assembly. wb_dat_o updates only at the end of SHIFT and holds otherwise.
- CS_HOLD (1 cycle): spi_cs_n_o=1. Next state is ACK.
- ACK: wb_ack_o=1 for exactly one cycle. Next state is IDLE.
- Latency: a read first sampled in cycle 0 gets its ack in cycle 3+128*CLK_DIV (259 for CLK_DIV=2).
- Back-to-back: a request still present in the IDLE cycle after ACK is accepted as a new request. CS_n is high for at least 2 cycles between frames.
- Abort: if wb_cyc_i drops in CS_SETUP or SHIFT, then next cycle spi_cs_n_o=1, SCK=0, FSM=IDLE. No ack, and wb_dat_o is unchanged.
- Reset mid-operation: outputs take their reset values at the next edge. CS_n goes high immediately.
- wb_ack_o and wb_err_o are never high together.

Decomposition:
- Package spi_flash_pkg: CMD_READ=8'h03, FRAME_BITS=64, state enum type.
- One sub-module, spi_sck_div: counter producing the rise_tick/fall_tick strobes every CLK_DIV cycles while enabled. It resets to 0 when disabled.

Test Plan:
- Reset: hold wb_rst_i for 3 cycles with stb high -> cs_n=1, sck=0, ack=0, err=0, dat_o=0 throughout.
- Read adr 0x0000_0104, CLK_DIV=2, flash model returns EF,BE,AD,DE -> MOSI stream 03 00 01 04, wb_dat_o=0xDEADBEEF, ack a single pulse at cycle 259, 64 SCK rising edges.
- Write to 0x0000_0010 -> wb_err_o pulses in cycle 1, cs_n stays 1, no SCK edges, no ack.
- Unaligned read adr 0xAB00_0107 -> address bytes sent 00 01 04; [31:24] and [1:0] are ignored.
- Read with wb_cyc_i dropped at cycle 100 -> cs_n=1 at cycle 101, no ack, dat_o unchanged. A following read of 0x000000 completes normally.
- CLK_DIV=1, read, with reset asserted at cycle 50 of a second read -> first read acks at cycle 131. On reset, all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the Wishbone SPI-flash read responder:
// READ command opcode, frame geometry, FSM state type and byte ordering helper.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 64;
    localparam int         BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ERR      = 3'd1,
        ST_CS_SETUP = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_CS_HOLD  = 3'd4,
        ST_ACK      = 3'd5
    } state_t;

    // The flash streams bytes MSB first; the first byte received must land
    // in bits [7:0] of the returned word (little-endian assembly).
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_div.sv
// SCK phase generator: while enabled, emits a rise strobe at the end of each
// low phase and a fall strobe at the end of each high phase, each phase
// lasting CLK_DIV clock cycles. Returns to the start of a low phase when
// disabled.
module spi_sck_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_wrap;

    assign w_wrap      = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise_tick = w_wrap && !r_phase;
    assign o_fall_tick = w_wrap &&  r_phase;

    // Count cycles within a phase; toggle the phase at each wrap
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wb_spi_flash_rd.sv
// Wishbone classic read-only responder for the SPI-flash slot. Each read
// runs one 64-bit READ (0x03) frame in SPI mode 0 and returns the 32 data
// bits little-endian; writes terminate with an error pulse.
module wb_spi_flash_rd
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        spi_sck_o,
    output logic        spi_cs_n_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    state_t                r_state;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [FRAME_BITS-1:0] r_tx;
    logic [31:0]           r_rx;

    logic                  w_req;
    logic                  w_abort;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_last_bit;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_unused;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_abort    = !wb_cyc_i && (r_state == ST_CS_SETUP || r_state == ST_SHIFT);
    assign w_frame    = {CMD_READ, wb_adr_i[ADDR_W-1:2], 2'b00, 32'h0000_0000};
    assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    // Write data, byte selects and the ignored address bits have no effect
    assign w_unused   = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_W], wb_adr_i[1:0]};

    spi_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .i_clk       (wb_clk_i),
        .i_rst       (wb_rst_i),
        .i_en        (r_state == ST_SHIFT),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );

    // Frame shift registers: load on accept, advance TX on SCK fall, capture MISO on SCK rise
    always_ff @(posedge wb_clk_i) begin
        if (r_state == ST_IDLE && w_req && !wb_we_i)
            r_tx <= w_frame;
        else if (r_state == ST_SHIFT && w_fall)
            r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
        if (r_state == ST_SHIFT && w_rise)
            r_rx <= {r_rx[30:0], spi_miso_i};
    end

    // Transaction FSM driving the bus handshake and the registered SPI pins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            wb_dat_o   <= '0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_cs_n_o <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            if (w_abort) begin
                // Master gave up the cycle: release the flash, no termination
                r_state    <= ST_IDLE;
                spi_cs_n_o <= 1'b1;
                spi_sck_o  <= 1'b0;
                spi_mosi_o <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_req && wb_we_i) begin
                            r_state  <= ST_ERR;
                            wb_err_o <= 1'b1;
                        end else if (w_req) begin
                            r_state    <= ST_CS_SETUP;
                            r_bit_cnt  <= '0;
                            spi_cs_n_o <= 1'b0;
                            spi_mosi_o <= w_frame[FRAME_BITS-1];
                        end
                    end
                    ST_ERR: r_state <= ST_IDLE;
                    ST_CS_SETUP: r_state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (w_rise) begin
                            spi_sck_o <= 1'b1;
                        end else if (w_fall) begin
                            spi_sck_o <= 1'b0;
                            if (w_last_bit) begin
                                spi_mosi_o <= 1'b0;
                                spi_cs_n_o <= 1'b1;
                                wb_dat_o   <= byte_swap32(r_rx);
                                r_state    <= ST_CS_HOLD;
                            end else begin
                                r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
                                spi_mosi_o <= r_tx[FRAME_BITS-2];
                            end
                        end
                    end
                    ST_CS_HOLD: begin
                        r_state  <= ST_ACK;
                        wb_ack_o <= 1'b1;
                    end
                    ST_ACK: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_spi_flash_rd.sv
// Self-checking bench for wb_spi_flash_rd: two instances (CLK_DIV=2 and
// CLK_DIV=1), each with a behavioural SPI flash model.
module tb_wb_spi_flash_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst1, cyc, stb, cyc1, stb1, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;

    logic [31:0] dat2, dat1;
    logic        ack2, err2, sck2, cs2_n, mosi2, miso2;
    logic        ack1, err1, sck1, cs1_n, mosi1, miso1;

    int n_checks = 0;
    int n_fail   = 0;

    // Flash models: stream = data bytes in transmission order (first byte in [31:24])
    logic [31:0] fl2_stream = '0, fl1_stream = '0;
    logic [63:0] fl2_rx = '0, fl1_rx = '0;
    int          fl2_cnt = 0, fl1_cnt = 0, fl2_rises = 0, fl1_rises = 0;

    wb_spi_flash_rd #(.CLK_DIV(2), .ADDR_W(24)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat2), .wb_ack_o(ack2),
        .wb_err_o(err2), .spi_sck_o(sck2), .spi_cs_n_o(cs2_n), .spi_mosi_o(mosi2),
        .spi_miso_i(miso2));

    wb_spi_flash_rd #(.CLK_DIV(1), .ADDR_W(24)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst1), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_dat_o(dat1), .wb_ack_o(ack1),
        .wb_err_o(err1), .spi_sck_o(sck1), .spi_cs_n_o(cs1_n), .spi_mosi_o(mosi1),
        .spi_miso_i(miso1));

    always @(posedge sck2) fl2_rises++;
    always @(posedge sck1) fl1_rises++;

    always @(posedge sck2 or posedge cs2_n) begin
        if (cs2_n) fl2_cnt = 0;
        else begin fl2_rx = {fl2_rx[62:0], mosi2}; fl2_cnt++; end
    end
    always @(posedge sck1 or posedge cs1_n) begin
        if (cs1_n) fl1_cnt = 0;
        else begin fl1_rx = {fl1_rx[62:0], mosi1}; fl1_cnt++; end
    end

    // After 32 command/address bits the flash presents data, MSB of each byte first
    always_comb begin
        miso2 = 1'b0;
        if (fl2_cnt >= 32 && fl2_cnt < 64) miso2 = fl2_stream[5'(63 - fl2_cnt)];
    end
    always_comb begin
        miso1 = 1'b0;
        if (fl1_cnt >= 32 && fl1_cnt < 64) miso1 = fl1_stream[5'(63 - fl1_cnt)];
    end

    function automatic logic [31:0] exp_hdr(input logic [31:0] a);
        return {8'h03, a[23:2], 2'b00};
    endfunction

    // Byte k received (k=0 first) goes to bits [8k+7:8k]
    function automatic logic [31:0] exp_word(input logic [31:0] stream);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            b = stream[31 - 8*k -: 8];
            w[8*k +: 8] = b;
        end
        return w;
    endfunction

    // Runs one read on the chosen instance; optional cyc drop or reset at a given cycle
    task automatic run_read(input int d, input logic [31:0] a, input int drop_at, input int rst_at,
                            output int ack_cyc, output int n_ack, output int n_err,
                            output int n_both, output int n_rises,
                            output logic [4:0] ctl_snap, output logic [31:0] dat_snap);
        int lat, r0;
        logic o_ack, o_err;
        lat = 3 + 128 * d;
        ack_cyc = -1; n_ack = 0; n_err = 0; n_both = 0;
        ctl_snap = '0; dat_snap = '0;
        r0 = (d == 1) ? fl1_rises : fl2_rises;
        @(posedge clk); #1;
        adr = a; we = 1'b0;
        if (d == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
        else begin cyc = 1'b1; stb = 1'b1; end
        for (int i = 1; i <= lat + 6; i++) begin
            @(posedge clk); #1;
            o_ack = (d == 1) ? ack1 : ack2;
            o_err = (d == 1) ? err1 : err2;
            if (i == drop_at + 1 || i == rst_at + 1) begin
                ctl_snap = (d == 1) ? {cs1_n, sck1, mosi1, ack1, err1}
                                    : {cs2_n, sck2, mosi2, ack2, err2};
                dat_snap = (d == 1) ? dat1 : dat2;
            end
            if (o_ack && o_err) n_both++;
            if (o_err) n_err++;
            if (o_ack) begin
                n_ack++;
                if (ack_cyc < 0) ack_cyc = i;
                cyc = 1'b0; stb = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
            end
            if (i == drop_at || i == rst_at) begin
                cyc = 1'b0; stb = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
            end
            if (i == rst_at) begin
                if (d == 1) rst1 = 1'b1; else rst = 1'b1;
            end
            if (i == rst_at + 1) begin rst = 1'b0; rst1 = 1'b0; end
        end
        n_rises = ((d == 1) ? fl1_rises : fl2_rises) - r0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1; we = 1'b0; adr = 32'h0000_0104;
        cyc = 1'b1; stb = 1'b1; cyc1 = 1'b1; stb1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (cs2_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs2_n); end
            n_checks++; if (sck2 !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", sck2); end
            n_checks++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack2); end
            n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err2); end
            n_checks++; if (dat2 !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", dat2); end
            n_checks++; if ({cs1_n, sck1, dat1} !== {1'b1, 1'b0, 32'h0}) begin
                n_fail++; $display("FAIL reset_div1: got cs=%b sck=%b dat=%h expected 1 0 0", cs1_n, sck1, dat1); end
        end
        rst = 1'b0; rst1 = 1'b0; cyc = 1'b0; stb = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        int ac, na, ne, nb, nr;
        logic [4:0] cs; logic [31:0] ds;
        fl2_stream = 32'hEFBE_ADDE;
        run_read(2, 32'h0000_0104, -1, -1, ac, na, ne, nb, nr, cs, ds);
        n_checks++; if (ac != 259) begin n_fail++; $display("FAIL basic_ack_cycle: got %0d expected 259", ac); end
        n_checks++; if (na != 1) begin n_fail++; $display("FAIL basic_ack_pulses: got %0d expected 1", na); end
        n_checks++; if (dat2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_dat: got %h expected deadbeef", dat2); end
        n_checks++; if (fl2_rx[63:32] !== 32'h0300_0104) begin n_fail++; $display("FAIL basic_mosi_hdr: got %h expected 03000104", fl2_rx[63:32]); end
        n_checks++; if (fl2_rx[31:0] !== 32'h0) begin n_fail++; $display("FAIL basic_mosi_data: got %h expected 0", fl2_rx[31:0]); end
        n_checks++; if (nr != 64) begin n_fail++; $display("FAIL basic_sck_rises: got %0d expected 64", nr); end
        n_checks++; if (ne != 0 || nb != 0) begin n_fail++; $display("FAIL basic_err: got err=%0d both=%0d expected 0 0", ne, nb); end
    endtask

    task automatic test_write();
        int r0, n_err, n_ack, err_cyc;
        logic cs_hi;
        r0 = fl2_rises; n_err = 0; n_ack = 0; err_cyc = -1; cs_hi = 1'b1;
        @(posedge clk); #1;
        adr = 32'h0000_0010; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack2) n_ack++;
            if (cs2_n !== 1'b1) cs_hi = 1'b0;
            if (err2) begin
                n_err++;
                if (err_cyc < 0) err_cyc = i;
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end
        end
        we = 1'b0;
        n_checks++; if (err_cyc != 1) begin n_fail++; $display("FAIL write_err_cycle: got %0d expected 1", err_cyc); end
        n_checks++; if (n_err != 1) begin n_fail++; $display("FAIL write_err_pulses: got %0d expected 1", n_err); end
        n_checks++; if (n_ack != 0) begin n_fail++; $display("FAIL write_ack: got %0d expected 0", n_ack); end
        n_checks++; if (cs_hi !== 1'b1) begin n_fail++; $display("FAIL write_cs_n: got low expected high"); end
        n_checks++; if (fl2_rises != r0) begin n_fail++; $display("FAIL write_sck: got %0d edges expected 0", fl2_rises - r0); end
    endtask

    task automatic test_unaligned();
        int ac, na, ne, nb, nr;
        logic [4:0] cs; logic [31:0] ds;
        fl2_stream = $urandom;
        run_read(2, 32'hAB00_0107, -1, -1, ac, na, ne, nb, nr, cs, ds);
        n_checks++; if (fl2_rx[63:32] !== 32'h0300_0104) begin n_fail++; $display("FAIL unaligned_hdr: got %h expected 03000104", fl2_rx[63:32]); end
        n_checks++; if (dat2 !== exp_word(fl2_stream)) begin n_fail++; $display("FAIL unaligned_dat: got %h expected %h", dat2, exp_word(fl2_stream)); end
        n_checks++; if (ac != 259) begin n_fail++; $display("FAIL unaligned_ack_cycle: got %0d expected 259", ac); end
    endtask

    task automatic test_random_reads();
        int ac, na, ne, nb, nr;
        logic [4:0] cs; logic [31:0] ds, a;
        for (int t = 0; t < 3; t++) begin
            a = $urandom; fl2_stream = $urandom;
            run_read(2, a, -1, -1, ac, na, ne, nb, nr, cs, ds);
            n_checks++; if (fl2_rx[63:32] !== exp_hdr(a)) begin n_fail++; $display("FAIL rand_hdr: got %h expected %h", fl2_rx[63:32], exp_hdr(a)); end
            n_checks++; if (dat2 !== exp_word(fl2_stream)) begin n_fail++; $display("FAIL rand_dat: got %h expected %h", dat2, exp_word(fl2_stream)); end
            n_checks++; if (ac != 259 || na != 1) begin n_fail++; $display("FAIL rand_ack: got cycle %0d pulses %0d expected 259 1", ac, na); end
        end
    endtask

    task automatic test_abort();
        int ac, na, ne, nb, nr;
        logic [4:0] cs; logic [31:0] ds, prev;
        prev = dat2;
        fl2_stream = ~fl2_stream;
        run_read(2, 32'h0012_3450, 100, -1, ac, na, ne, nb, nr, cs, ds);
        n_checks++; if (cs[4] !== 1'b1) begin n_fail++; $display("FAIL abort_cs_n: got %b expected 1", cs[4]); end
        n_checks++; if (cs[3] !== 1'b0) begin n_fail++; $display("FAIL abort_sck: got %b expected 0", cs[3]); end
        n_checks++; if (na != 0) begin n_fail++; $display("FAIL abort_ack: got %0d expected 0", na); end
        n_checks++; if (dat2 !== prev || ds !== prev) begin n_fail++; $display("FAIL abort_dat: got %h expected %h", dat2, prev); end
        fl2_stream = $urandom;
        run_read(2, 32'h0000_0000, -1, -1, ac, na, ne, nb, nr, cs, ds);
        n_checks++; if (ac != 259 || na != 1) begin n_fail++; $display("FAIL after_abort_ack: got cycle %0d pulses %0d expected 259 1", ac, na); end
        n_checks++; if (dat2 !== exp_word(fl2_stream)) begin n_fail++; $display("FAIL after_abort_dat: got %h expected %h", dat2, exp_word(fl2_stream)); end
        n_checks++; if (fl2_rx[63:32] !== 32'h0300_0000) begin n_fail++; $display("FAIL after_abort_hdr: got %h expected 03000000", fl2_rx[63:32]); end
    endtask

    task automatic test_back_to_back();
        int first, second, run;
        logic seen_low, started2;
        logic [31:0] a1, a2, s2, d1, d2;
        first = -1; second = -1; run = 0; seen_low = 1'b0; started2 = 1'b0;
        a1 = $urandom; a2 = $urandom;
        fl2_stream = $urandom; s2 = $urandom;
        d1 = exp_word(fl2_stream);
        d2 = '0;
        @(posedge clk); #1;
        adr = a1; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 2 * 259 + 10; i++) begin
            @(posedge clk); #1;
            if (!cs2_n) begin
                if (run > 0) started2 = 1'b1;
                seen_low = 1'b1;
            end else if (seen_low && !started2) begin
                run++;
            end
            if (ack2) begin
                if (first < 0) begin
                    first = i;
                    n_checks++; if (dat2 !== d1) begin n_fail++; $display("FAIL b2b_dat1: got %h expected %h", dat2, d1); end
                    fl2_stream = s2; adr = a2;
                end else if (second < 0) begin
                    second = i; d2 = dat2;
                    cyc = 1'b0; stb = 1'b0;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        n_checks++; if (first != 259) begin n_fail++; $display("FAIL b2b_ack1: got %0d expected 259", first); end
        n_checks++; if (second != 519) begin n_fail++; $display("FAIL b2b_ack2: got %0d expected 519", second); end
        n_checks++; if (d2 !== exp_word(s2)) begin n_fail++; $display("FAIL b2b_dat2: got %h expected %h", d2, exp_word(s2)); end
        n_checks++; if (fl2_rx[63:32] !== exp_hdr(a2)) begin n_fail++; $display("FAIL b2b_hdr2: got %h expected %h", fl2_rx[63:32], exp_hdr(a2)); end
        n_checks++; if (run < 2) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected >=2", run); end
    endtask

    task automatic test_clkdiv1_reset();
        int ac, na, ne, nb, nr;
        logic [4:0] cs; logic [31:0] ds, a;
        a = $urandom; fl1_stream = $urandom | 32'h0000_0080;
        run_read(1, a, -1, -1, ac, na, ne, nb, nr, cs, ds);
        n_checks++; if (ac != 131 || na != 1) begin n_fail++; $display("FAIL div1_ack: got cycle %0d pulses %0d expected 131 1", ac, na); end
        n_checks++; if (dat1 !== exp_word(fl1_stream)) begin n_fail++; $display("FAIL div1_dat: got %h expected %h", dat1, exp_word(fl1_stream)); end
        n_checks++; if (fl1_rx[63:32] !== exp_hdr(a) || nr != 64) begin
            n_fail++; $display("FAIL div1_frame: got hdr %h rises %0d expected %h 64", fl1_rx[63:32], nr, exp_hdr(a)); end
        fl1_stream = $urandom;
        run_read(1, $urandom, -1, 50, ac, na, ne, nb, nr, cs, ds);
        n_checks++; if (cs !== 5'b10000) begin n_fail++; $display("FAIL div1_rst_ctl: got cs,sck,mosi,ack,err=%b expected 10000", cs); end
        n_checks++; if (ds !== 32'h0) begin n_fail++; $display("FAIL div1_rst_dat: got %h expected 0", ds); end
        n_checks++; if (na != 0) begin n_fail++; $display("FAIL div1_rst_ack: got %0d expected 0", na); end
    endtask

    initial begin
        wdat = 32'hFFFF_FFFF; sel = 4'hF;
        test_reset();
        test_read_basic();
        test_write();
        test_unaligned();
        test_random_reads();
        test_abort();
        test_back_to_back();
        test_clkdiv1_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
